mux_cfg_parser: RTL and testbench

- Upstream configuration stage for the GPIO console mux.
- Consumes a byte stream from the host serial receiver and decodes short commands.
- Maintains the `selectors` and `enabled_out` registers that drive the mux directly.
- Returns one status or readback byte per command on a transmit handshake.

---
 rtl/mux_cfg_parser.sv | 193 +++++++++++++++++++
 tb/tb_mux_cfg_parser.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_cfg_parser.sv
// mux_cfg_parser: byte-stream command decoder for the GPIO console mux.
// It accepts one- and two-byte commands from the serial receiver, updates the
// selector and enable registers that drive the mux, and returns one response
// byte per completed command.
//
// Handshakes: a byte moves on a rising edge where valid and ready are both high.
// The sender holds data steady while valid is high and ready is low. This holds
// for rx_valid/rx_ready (host to parser) and tx_valid/tx_ready (parser to host).
// tx_data does not change while tx_valid is high.
module mux_cfg_parser #(
   parameter int INPUT_COUNT    = 4,
   parameter int OUTPUT_COUNT   = 4,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [7:0]                rx_data,
   input  logic                      rx_valid,
   output logic                      rx_ready,
   output logic [7:0]                tx_data,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   output logic [4*OUTPUT_COUNT-1:0] selectors,
   output logic [OUTPUT_COUNT-1:0]   enabled_out,
   output logic                      cmd_error
);

   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [4:0]    IN_CNT   = 5'(INPUT_COUNT);
   localparam logic [4:0]    OUT_CNT  = 5'(OUTPUT_COUNT);

   localparam logic [7:0] OP_SET   = 8'h53;
   localparam logic [7:0] OP_EN    = 8'h45;
   localparam logic [7:0] OP_RD    = 8'h52;
   localparam logic [7:0] OP_CLR   = 8'h43;
   localparam logic [7:0] RESP_OK  = 8'h4B;
   localparam logic [7:0] RESP_ERR = 8'h21;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARG  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [7:0]                op_q, op_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [4*OUTPUT_COUNT-1:0] sel_q, sel_d;
   logic [OUTPUT_COUNT-1:0]   en_q, en_d;
   logic [7:0]                tx_data_q, tx_data_d;
   logic                      tx_valid_q, tx_valid_d;
   logic                      err_q, err_d;

   logic       rx_accept;
   logic [3:0] out_idx;
   logic [3:0] in_idx;
   logic       arg_bad;
   logic [3:0] rb_sel;
   logic       rb_en;

   // Ready is forced low during reset so no byte is taken while state is undefined.
   assign rx_ready  = ~rst & (state_q != ST_RESP);
   assign rx_accept = rx_valid & rx_ready;
   assign out_idx   = rx_data[7:4];
   assign in_idx    = rx_data[3:0];

   assign selectors   = sel_q;
   assign enabled_out = en_q;
   assign tx_data     = tx_data_q;
   assign tx_valid    = tx_valid_q;
   assign cmd_error   = err_q;

   // Fetch the addressed output's current selector and enable bit for readback.
   always_comb begin
      rb_sel = 4'd0;
      rb_en  = 1'b0;
      for (int k = 0; k < OUTPUT_COUNT; k++) begin
         if (out_idx == 4'(k)) begin
            rb_sel = sel_q[4*k +: 4];
            rb_en  = en_q[k];
         end
      end
   end

   // Reject arguments that address a missing output, or a missing input for 'S'.
   always_comb begin
      arg_bad = ({1'b0, out_idx} >= OUT_CNT);
      if ((op_q == OP_SET) && ({1'b0, in_idx} >= IN_CNT)) begin
         arg_bad = 1'b1;
      end
   end

   // Next-state logic: command decoding, register writes, response and timeout.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      sel_d      = sel_q;
      en_d       = en_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      err_d      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (rx_accept) begin
               if ((rx_data == OP_SET) || (rx_data == OP_EN) || (rx_data == OP_RD)) begin
                  op_d    = rx_data;
                  cnt_d   = '0;
                  state_d = ST_ARG;
               end else if (rx_data == OP_CLR) begin
                  sel_d      = '0;
                  en_d       = '0;
                  tx_data_d  = RESP_OK;
                  tx_valid_d = 1'b1;
                  state_d    = ST_RESP;
               end else begin
                  tx_data_d  = RESP_ERR;
                  tx_valid_d = 1'b1;
                  err_d      = 1'b1;
                  state_d    = ST_RESP;
               end
            end
         end

         ST_ARG: begin
            // An argument arriving on the expiry cycle still wins over the abort.
            if (rx_accept) begin
               tx_valid_d = 1'b1;
               state_d    = ST_RESP;
               if (arg_bad) begin
                  tx_data_d = RESP_ERR;
                  err_d     = 1'b1;
               end else if (op_q == OP_RD) begin
                  tx_data_d = {rb_en, 3'b000, rb_sel};
               end else begin
                  tx_data_d = RESP_OK;
                  for (int k = 0; k < OUTPUT_COUNT; k++) begin
                     if (out_idx == 4'(k)) begin
                        if (op_q == OP_SET) begin
                           sel_d[4*k +: 4] = in_idx;
                        end else begin
                           en_d[k] = rx_data[0];
                        end
                     end
                  end
               end
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         ST_RESP: begin
            if (tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset discards any in-flight command.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         op_q       <= 8'd0;
         cnt_q      <= '0;
         sel_q      <= '0;
         en_q       <= '0;
         tx_data_q  <= 8'd0;
         tx_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         en_q       <= en_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_mux_cfg_parser.sv
// Bench for mux_cfg_parser: directed test-plan steps followed by random
// commands, all checked against a per-output array model of the mux registers.
module tb_mux_cfg_parser;

   localparam int NIN  = 4;
   localparam int NOUT = 4;
   localparam int TO   = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [7:0]      rx_data = 8'd0;
   logic            rx_valid = 1'b0;
   logic            rx_ready;
   logic [7:0]      tx_data;
   logic            tx_valid;
   logic            tx_ready = 1'b0;
   logic [4*NOUT-1:0] selectors;
   logic [NOUT-1:0] enabled_out;
   logic            cmd_error;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model: one selector and one enable per output.
   int sel_m [NOUT];
   int en_m  [NOUT];
   logic [7:0] exp_q[$];

   mux_cfg_parser #(
      .INPUT_COUNT(NIN),
      .OUTPUT_COUNT(NOUT),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .selectors(selectors),
      .enabled_out(enabled_out),
      .cmd_error(cmd_error)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_reset();
      for (int k = 0; k < NOUT; k++) begin
         sel_m[k] = 0;
         en_m[k]  = 0;
      end
   endfunction

   function automatic logic [4*NOUT-1:0] sel_pack();
      logic [4*NOUT-1:0] v = '0;
      for (int k = 0; k < NOUT; k++) v[4*k +: 4] = 4'(sel_m[k]);
      return v;
   endfunction

   function automatic logic [NOUT-1:0] en_pack();
      logic [NOUT-1:0] v = '0;
      for (int k = 0; k < NOUT; k++) v[k] = (en_m[k] != 0);
      return v;
   endfunction

   function automatic bit takes_arg(input logic [7:0] op);
      return (op == 8'h53) || (op == 8'h45) || (op == 8'h52);
   endfunction

   // Apply one complete command to the model; returns expected response and error.
   function automatic void model_cmd(input logic [7:0] op, input logic [7:0] arg,
                                     output logic [7:0] resp, output bit err);
      int oi = int'(arg[7:4]);
      int ii = int'(arg[3:0]);
      resp = 8'h4B;
      err  = 1'b0;
      if (op == 8'h43) begin
         model_reset();
      end else if (!takes_arg(op)) begin
         resp = 8'h21;
         err  = 1'b1;
      end else if (oi >= NOUT || (op == 8'h53 && ii >= NIN)) begin
         resp = 8'h21;
         err  = 1'b1;
      end else if (op == 8'h53) begin
         sel_m[oi] = ii;
      end else if (op == 8'h45) begin
         en_m[oi] = int'(arg[0]);
      end else begin
         resp = {en_m[oi] != 0, 3'b000, 4'(sel_m[oi])};
      end
   endfunction

   // Drive one byte and hold it until accepted (bounded wait).
   task automatic send_byte(input logic [7:0] b);
      int budget = 50;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && budget > 0) begin
         tick();
         budget--;
      end
      if (budget == 0) check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
      tick();
      rx_valid = 1'b0;
   endtask

   // Full command: bytes in, response checked, then drained after a random stall.
   task automatic run_cmd(input string tag, input logic [7:0] op, input logic [7:0] arg);
      logic [7:0] resp;
      bit err;
      logic [7:0] exp_b;
      int stall;
      model_cmd(op, arg, resp, err);
      exp_q.push_back(resp);
      send_byte(op);
      if (takes_arg(op)) begin
         repeat ($urandom_range(0, 2)) tick();
         send_byte(arg);
      end
      exp_b = exp_q.pop_front();
      check({tag, "_txv"}, {31'd0, tx_valid}, 32'd1);
      check({tag, "_txd"}, {24'd0, tx_data}, {24'd0, exp_b});
      check({tag, "_err"}, {31'd0, cmd_error}, {31'd0, err});
      check({tag, "_sel"}, {16'd0, selectors}, {16'd0, sel_pack()});
      check({tag, "_en"}, {28'd0, enabled_out}, {28'd0, en_pack()});
      check({tag, "_rxr_resp"}, {31'd0, rx_ready}, 32'd0);
      stall = $urandom_range(0, 3);
      repeat (stall) tick();
      if (stall > 0) check({tag, "_txd_hold"}, {24'd0, tx_data}, {24'd0, exp_b});
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      check({tag, "_txv_drop"}, {31'd0, tx_valid}, 32'd0);
      check({tag, "_rxr_idle"}, {31'd0, rx_ready}, 32'd1);
      check({tag, "_err_pulse"}, {31'd0, cmd_error}, 32'd0);
   endtask

   initial begin
      logic [7:0] op;
      logic [7:0] arg;
      model_reset();

      // Reset values
      #1;
      check("rst_rxr", {31'd0, rx_ready}, 32'd0);
      tick();
      tick();
      check("rst_sel", {16'd0, selectors}, 32'd0);
      check("rst_en", {28'd0, enabled_out}, 32'd0);
      check("rst_txv", {31'd0, tx_valid}, 32'd0);
      check("rst_txd", {24'd0, tx_data}, 32'd0);
      check("rst_err", {31'd0, cmd_error}, 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_rxr", {31'd0, rx_ready}, 32'd1);

      // Directed commands
      run_cmd("set12", 8'h53, 8'h12);
      check("set12_slice", {28'd0, selectors[7:4]}, 32'd2);
      run_cmd("en11", 8'h45, 8'h11);
      run_cmd("rd10", 8'h52, 8'h10);
      run_cmd("set_badout", 8'h53, 8'h47);
      run_cmd("set_badin", 8'h53, 8'h04);
      run_cmd("bad_op", 8'h7A, 8'h00);
      run_cmd("clear", 8'h43, 8'h00);
      run_cmd("en_rsv", 8'h45, 8'h2F);
      run_cmd("rd_out3", 8'h52, 8'h3F);

      // Timeout abort: no argument for TO cycles after the opcode
      send_byte(8'h45);
      repeat (TO - 1) begin
         tick();
         check("to_wait_err", {31'd0, cmd_error}, 32'd0);
      end
      tick();
      check("to_err", {31'd0, cmd_error}, 32'd1);
      check("to_txv", {31'd0, tx_valid}, 32'd0);
      check("to_rxr", {31'd0, rx_ready}, 32'd1);
      check("to_en", {28'd0, enabled_out}, {28'd0, en_pack()});
      tick();
      check("to_err_clear", {31'd0, cmd_error}, 32'd0);

      // Argument on the expiry cycle is still processed
      send_byte(8'h45);
      repeat (TO - 1) tick();
      begin
         logic [7:0] r;
         bit e;
         model_cmd(8'h45, 8'h01, r, e);
         rx_data  = 8'h01;
         rx_valid = 1'b1;
         tick();
         rx_valid = 1'b0;
         check("exp_arg_txv", {31'd0, tx_valid}, 32'd1);
         check("exp_arg_txd", {24'd0, tx_data}, {24'd0, r});
         check("exp_arg_err", {31'd0, cmd_error}, 32'd0);
         check("exp_arg_en", {28'd0, enabled_out}, {28'd0, en_pack()});
         tx_ready = 1'b1;
         tick();
         tx_ready = 1'b0;
      end

      // Long tx stall: response held, bytes ignored, then reset mid-response
      begin
         logic [7:0] r;
         bit e;
         model_cmd(8'h53, 8'h31, r, e);
         send_byte(8'h53);
         send_byte(8'h31);
         rx_data  = 8'h43;
         rx_valid = 1'b1;
         repeat (20) begin
            check("stall_txv", {31'd0, tx_valid}, 32'd1);
            check("stall_txd", {24'd0, tx_data}, {24'd0, r});
            check("stall_rxr", {31'd0, rx_ready}, 32'd0);
            tick();
         end
         rx_valid = 1'b0;
         check("stall_sel", {16'd0, selectors}, {16'd0, sel_pack()});
         check("stall_en", {28'd0, enabled_out}, {28'd0, en_pack()});
         rst = 1'b1;
         #1;
         model_reset();
         exp_q.delete();
         check("midrst_txv", {31'd0, tx_valid}, 32'd0);
         check("midrst_sel", {16'd0, selectors}, 32'd0);
         check("midrst_en", {28'd0, enabled_out}, 32'd0);
         check("midrst_rxr", {31'd0, rx_ready}, 32'd0);
         tick();
         rst = 1'b0;
         #1;
      end

      // Random commands
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 5))
            0, 1: op = 8'h53;
            2:    op = 8'h45;
            3:    op = 8'h52;
            4:    op = ($urandom_range(0, 3) == 0) ? 8'h43 : 8'h53;
            default: op = 8'($urandom_range(0, 255));
         endcase
         arg = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 15))};
         if ($urandom_range(0, 3) != 0) arg[3:0] = 4'($urandom_range(0, 5));
         run_cmd("rand", op, arg);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
